// File: rtl/cb_branch_pkg.sv
// Shared definitions for the clocked four-phase branch (fork) stage:
// FSM state encodings, branch select constants and the dest-ack mux.
package cb_branch_pkg;

   localparam logic BR_A = 1'b0;
   localparam logic BR_B = 1'b1;

   typedef logic [0:0] in_state_t;
   localparam in_state_t I_IDLE = 1'b0;
   localparam in_state_t I_ACK  = 1'b1;

   typedef logic [1:0] out_state_t;
   localparam out_state_t O_IDLE = 2'b00;
   localparam out_state_t O_REQ  = 2'b01;
   localparam out_state_t O_RTZ  = 2'b10;

   function automatic logic ack_of(input logic dest, input logic ack_a, input logic ack_b);
      return (dest == BR_B) ? ack_b : ack_a;
   endfunction

endpackage

// File: rtl/cb_out_hs.sv
// Four-phase output handshake: one request steered to branch a or b.
// The destination is latched on request so a new capture during RTZ cannot disturb it.
module cb_out_hs
   import cb_branch_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic dest,
   input  logic ack_a,
   input  logic ack_b,
   output logic send_a,
   output logic send_b,
   output logic done
);

   out_state_t state_r;
   out_state_t state_next_s;
   logic       dest_r;
   logic       dest_next_s;
   logic       ack_sel_s;
   logic       send_a_r;
   logic       send_b_r;
   logic       done_s;

   assign ack_sel_s = ack_of(dest_r, ack_a, ack_b);

   // Next-state decode; done marks the acknowledge that empties the token register.
   always_comb begin
      state_next_s = state_r;
      dest_next_s  = dest_r;
      done_s       = 1'b0;
      case (state_r)
         O_IDLE: begin
            if (start) begin
               state_next_s = O_REQ;
               dest_next_s  = dest;
            end else begin
               state_next_s = O_IDLE;
            end
         end
         O_REQ: begin
            if (ack_sel_s) begin
               state_next_s = O_RTZ;
               done_s       = 1'b1;
            end else begin
               state_next_s = O_REQ;
            end
         end
         O_RTZ: begin
            if (!ack_sel_s) begin
               state_next_s = O_IDLE;
            end else begin
               state_next_s = O_RTZ;
            end
         end
         default: begin
            state_next_s = O_IDLE;
         end
      endcase
   end

   // State, latched destination and registered requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= O_IDLE;
         dest_r   <= BR_A;
         send_a_r <= 1'b0;
         send_b_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         dest_r   <= dest_next_s;
         send_a_r <= (state_next_s == O_REQ) && (dest_next_s == BR_A);
         send_b_r <= (state_next_s == O_REQ) && (dest_next_s == BR_B);
      end
   end

   assign send_a = send_a_r;
   assign send_b = send_b_r;
   assign done   = done_s;

endmodule

// File: rtl/cb_branch.sv
// Clocked four-phase branch stage: one input channel, token steered to a or b
// by its routing bit, single-entry buffer between input and output handshakes.
module cb_branch
   import cb_branch_pkg::*;
#(
   parameter int DW      = 16,
   parameter int SEL_BIT = DW - 1
)(
   input  logic          CP,
   input  logic          MR_n,
   input  logic          Send_in,
   input  logic [DW-1:0] Data_in,
   output logic          Ack_out,
   output logic          Send_out_a,
   input  logic          Ack_in_a,
   output logic          Send_out_b,
   input  logic          Ack_in_b,
   output logic [DW-1:0] Data_out,
   output logic          CP_a,
   output logic          CP_b
);

   in_state_t     in_state_r;
   in_state_t     in_next_s;
   logic          capture_s;
   logic          full_r;
   logic          dest_r;
   logic [DW-1:0] data_r;
   logic          cp_a_r;
   logic          cp_b_r;
   logic          done_s;

   // Input FSM decode; capture looks at the registered full flag only.
   always_comb begin
      in_next_s = in_state_r;
      capture_s = 1'b0;
      case (in_state_r)
         I_IDLE: begin
            if (Send_in && !full_r) begin
               in_next_s = I_ACK;
               capture_s = 1'b1;
            end else begin
               in_next_s = I_IDLE;
            end
         end
         I_ACK: begin
            if (!Send_in) begin
               in_next_s = I_IDLE;
            end else begin
               in_next_s = I_ACK;
            end
         end
         default: begin
            in_next_s = I_IDLE;
         end
      endcase
   end

   // Token register, full flag and capture pulses.
   always_ff @(posedge CP or negedge MR_n) begin
      if (!MR_n) begin
         in_state_r <= I_IDLE;
         full_r     <= 1'b0;
         dest_r     <= BR_A;
         data_r     <= {DW{1'b0}};
         cp_a_r     <= 1'b0;
         cp_b_r     <= 1'b0;
      end else begin
         in_state_r <= in_next_s;
         cp_a_r     <= capture_s && (Data_in[SEL_BIT] == BR_A);
         cp_b_r     <= capture_s && (Data_in[SEL_BIT] == BR_B);
         if (capture_s) begin
            data_r <= Data_in;
            dest_r <= Data_in[SEL_BIT];
            full_r <= 1'b1;
         end else if (done_s) begin
            full_r <= 1'b0;
         end
      end
   end

   cb_out_hs u_out_hs (
      .clk    (CP),
      .rst_n  (MR_n),
      .start  (full_r),
      .dest   (dest_r),
      .ack_a  (Ack_in_a),
      .ack_b  (Ack_in_b),
      .send_a (Send_out_a),
      .send_b (Send_out_b),
      .done   (done_s)
   );

   assign Ack_out  = (in_state_r == I_ACK);
   assign Data_out = data_r;
   assign CP_a     = cp_a_r;
   assign CP_b     = cp_b_r;

endmodule

// File: tb/tb_cb_branch.sv
// Directed table-driven bench for cb_branch plus reset and token-stream sequences.
module tb_cb_branch;

   logic        CP;
   logic        MR_n;
   logic        Send_in;
   logic [15:0] Data_in;
   logic        Ack_out;
   logic        Send_out_a;
   logic        Ack_in_a;
   logic        Send_out_b;
   logic        Ack_in_b;
   logic [15:0] Data_out;
   logic        CP_a;
   logic        CP_b;

   int checks = 0;
   int errors = 0;

   cb_branch #(.DW(16), .SEL_BIT(15)) dut (
      .CP         (CP),
      .MR_n       (MR_n),
      .Send_in    (Send_in),
      .Data_in    (Data_in),
      .Ack_out    (Ack_out),
      .Send_out_a (Send_out_a),
      .Ack_in_a   (Ack_in_a),
      .Send_out_b (Send_out_b),
      .Ack_in_b   (Ack_in_b),
      .Data_out   (Data_out),
      .CP_a       (CP_a),
      .CP_b       (CP_b)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   typedef struct {
      logic        send;
      logic [15:0] din;
      logic        aa;
      logic        ab;
      logic        e_ack;
      logic        e_sa;
      logic        e_sb;
      logic        e_cpa;
      logic        e_cpb;
      logic [15:0] e_dout;
   } vec_t;

   vec_t vecs[23];

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [20:0] outs();
      return {Ack_out, Send_out_a, Send_out_b, CP_a, CP_b, Data_out};
   endfunction

   initial begin
      logic [15:0] exp_q[$];
      logic [15:0] tok;
      logic [15:0] e;
      int sent;
      int got;

      // send, din, ack_a, ack_b | Ack_out, Send_out_a, Send_out_b, CP_a, CP_b, Data_out
      vecs[0]  = '{1'b1, 16'h8005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8005};
      vecs[1]  = '{1'b0, 16'h8005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h8005};
      vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h8005};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8005};
      vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8005};
      vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8005};
      vecs[6]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001};
      vecs[7]  = '{1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001};
      vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001};
      vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001};
      vecs[10] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001};
      vecs[11] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001};
      vecs[12] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001};
      vecs[13] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002};
      vecs[14] = '{1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002};
      vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002};
      vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002};
      vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002};
      vecs[18] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234};
      vecs[19] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234};
      vecs[20] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
      vecs[21] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
      vecs[22] = '{1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};

      MR_n     = 1'b0;
      Send_in  = 1'b1;
      Data_in  = 16'h8005;
      Ack_in_a = 1'b0;
      Ack_in_b = 1'b0;
      repeat (3) step();
      chk("reset_outputs", 64'(outs()), 64'(21'h0));
      MR_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         Send_in  = vecs[i].send;
         Data_in  = vecs[i].din;
         Ack_in_a = vecs[i].aa;
         Ack_in_b = vecs[i].ab;
         step();
         chk($sformatf("vec%0d", i), 64'(outs()),
             64'({vecs[i].e_ack, vecs[i].e_sa, vecs[i].e_sb,
                  vecs[i].e_cpa, vecs[i].e_cpb, vecs[i].e_dout}));
      end

      // Reset dropped asynchronously while branch a is requesting.
      Send_in = 1'b1;
      Data_in = 16'h4321;
      step();
      Send_in = 1'b0;
      step();
      chk("pre_reset_send_a", 64'(Send_out_a), 64'(1'b1));
      #2;
      MR_n = 1'b0;
      #1;
      chk("async_reset_outputs", 64'(outs()), 64'(21'h0));
      step();
      MR_n = 1'b1;
      step();
      chk("after_reset_idle", 64'(outs()), 64'(21'h0));
      Send_in = 1'b1;
      Data_in = 16'hC0DE;
      step();
      chk("after_reset_capture", 64'(outs()), 64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0DE}));
      Send_in = 1'b0;
      step();
      chk("after_reset_send_b", 64'({Send_out_a, Send_out_b}), 64'(2'b01));
      Ack_in_b = 1'b1;
      step();
      Ack_in_b = 1'b0;
      step();

      // Alternating a/b token stream with zero-delay peers.
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
         if ((Send_out_a && !Ack_in_a) || (Send_out_b && !Ack_in_b)) begin
            if (exp_q.size() == 0) begin
               chk("stream_unexpected_token", 64'(Data_out), 64'(16'hXXXX));
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("stream_data%0d", got), 64'(Data_out), 64'(e));
               chk($sformatf("stream_branch%0d", got), 64'({Send_out_a, Send_out_b}),
                   64'(e[15] ? 2'b01 : 2'b10));
            end
            got++;
         end
         if (Send_out_a && Send_out_b) begin
            chk("stream_one_hot", 64'({Send_out_a, Send_out_b}), 64'(2'b00));
         end
         Ack_in_a = Send_out_a;
         Ack_in_b = Send_out_b;
         if (Send_in && Ack_out) begin
            Send_in = 1'b0;
         end else if (!Send_in && !Ack_out && sent < 100) begin
            tok = 16'($urandom_range(0, 32767));
            tok[15] = sent[0];
            Data_in = tok;
            Send_in = 1'b1;
            exp_q.push_back(tok);
            sent++;
         end
         step();
      end
      chk("stream_token_count", 64'(got), 64'(100));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
